// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy state encoding and bubble counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

   // Occupancy of a pipeline stage: nothing held, main register full, main and skid full.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int BUBBLE_CNT_W = 16;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage with stall, flush and a saturating bubble counter.
// Latency: one cycle from input transfer to out_data when the stage was empty.
// Backpressure: default in_ready follows out_ready combinationally; with PIPE_SKID_EN
//    a skid entry absorbs one extra payload and in_ready depends on state only.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   input  logic                    stall,
   input  logic                    flush,
   output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

   localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = 'd1;
   localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = '1;

   pipe_state_e             state_q, state_d;
   logic [WIDTH-1:0]        main_q, main_d;
   logic [BUBBLE_CNT_W-1:0] bubble_q, bubble_d;
   logic                    in_xfer;
   logic                    out_xfer;

`ifdef PIPE_SKID_EN
   logic [WIDTH-1:0]        skid_q, skid_d;

   // Ready depends only on occupancy, so out_ready never reaches in_ready.
   assign in_ready = rst & ~stall & ~flush & (state_q != TWO);
`else
   // Without a skid entry a full stage can only accept when it is draining this cycle.
   assign in_ready = rst & ~stall & ~flush & ((state_q == EMPTY) | out_ready);
`endif

   // A stalled stage presents a bubble even when it holds a payload.
   assign out_valid  = (state_q != EMPTY) & ~stall;
   assign out_data   = out_valid ? main_q : NOP_VALUE;
   assign bubble_cnt = bubble_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // Next occupancy and payload movement; flush wins over everything else.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_SKID_EN
      skid_d  = skid_q;
`endif
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_data;
               end else if (out_xfer) begin
                  state_d = EMPTY;
`ifdef PIPE_SKID_EN
               end else if (in_xfer) begin
                  state_d = TWO;
                  skid_d  = in_data;
`endif
               end
            end
`ifdef PIPE_SKID_EN
            TWO: begin
               if (out_xfer) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   // Count every cycle the output shows a bubble, holding at the maximum.
   always_comb begin
      bubble_d = bubble_q;
      if (!out_valid && (bubble_q != CNT_MAX)) begin
         bubble_d = bubble_q + CNT_ONE;
      end
   end

   // State, main payload and bubble counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= EMPTY;
         main_q   <= NOP_VALUE;
         bubble_q <= '0;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         bubble_q <= bubble_d;
      end
   end

`ifdef PIPE_SKID_EN
   // Skid payload register, only present when the extra entry is built.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_q <= NOP_VALUE;
      end else begin
         skid_q <= skid_d;
      end
   end
`endif

endmodule : pipe_stage_reg

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter NOP_VALUE, default {WIDTH{1'b0}}, value driven on out_data whenever out_valid is 0.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  downstream payload valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port stall  input  1  freeze stage; output presented as bubble.
REQ-012 SHALL have port flush  input  1  discard all held entries.
REQ-013 SHALL have port bubble_cnt  output  16  saturating count of cycles with out_valid=0.

Function
REQ-014 SHALL perform an input transfer when in_valid & in_ready, and an output transfer when out_valid & out_ready, both at the rising clk edge.
REQ-015 SHALL hold entries in a state machine: EMPTY (0 entries), ONE (main register full), TWO (main and skid full; reachable only with PIPE_SKID_EN).
REQ-016 SHALL transition EMPTY->ONE on input transfer, ONE->EMPTY on output-only transfer, ONE->ONE on simultaneous input and output transfer (main register reloaded), ONE->TWO on input-only transfer, TWO->ONE on output transfer (skid moves to main).
REQ-017 SHALL drive out_valid = (state != EMPTY) & ~stall, and out_data = main register when out_valid=1, else NOP_VALUE.
REQ-018 SHALL, with stall=1, force in_ready=0, hold state and all registers, and count the cycle as a bubble.
REQ-019 SHALL, with flush=1, force in_ready=0 and go to EMPTY at the next edge regardless of stall, out_ready or state; flush has priority over stall.
REQ-020 SHALL give latency of exactly one cycle: data accepted at edge N appears on out_data after edge N when the stage was EMPTY.
REQ-021 SHALL increment bubble_cnt by 1 at each edge where out_valid was 0, saturating at 16'hFFFF; flush does not clear it.
REQ-022 SHALL preserve payload order; no payload is duplicated or dropped except by flush.

Reset
REQ-023 SHALL, while rst=0, asynchronously force state=EMPTY, main and skid registers=NOP_VALUE, bubble_cnt=0, out_valid=0 and in_ready=0.
REQ-024 SHALL, after rst is deasserted mid-operation, resume at the first rising edge with EMPTY state; in-flight payloads are lost.

Configuration
REQ-025 SHALL compile the skid entry in when PIPE_SKID_EN is defined: in_ready = (state != TWO) & ~stall & ~flush, registered from state only, with no combinational path from out_ready.
REQ-026 SHALL, without PIPE_SKID_EN, omit the skid register: in_ready = ~stall & ~flush & ((state==EMPTY) | out_ready); state TWO is not implemented.

Structure
REQ-027 SHALL take the state encoding typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and BUBBLE_CNT_W=16 from shared package pipe_pkg.
REQ-028 SHALL be implemented as a single module with no sub-modules; the datapath and FSM are small enough to be flat.

Verification
REQ-029 SHALL cover streaming: WIDTH=32, in_valid=1 with payloads 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, one-cycle latency, bubble_cnt=1 (first cycle only).
REQ-030 SHALL cover backpressure with PIPE_SKID_EN: load 0xA, out_ready=0, offer 0xB, then 0xC -> state TWO, in_ready=0, 0xC not accepted; out_ready=1 -> 0xA, 0xB, 0xC emitted in order.
REQ-031 SHALL cover stall: state ONE holding 0x55, stall=1 for 3 cycles -> out_valid=0, out_data=NOP_VALUE, bubble_cnt +3; stall=0 -> 0x55 emitted.
REQ-032 SHALL cover flush vs stall: state TWO, flush=1 and stall=1 in the same cycle -> EMPTY next edge, out_valid=0, nothing emitted.
REQ-033 SHALL cover saturation and reset: idle for 70000 cycles -> bubble_cnt=16'hFFFF; rst=0 asserted mid-stream -> outputs reset immediately without a clock edge.
